// File: rtl/writeback_arbiter_l1.sv
// Writeback stage: round-robin arbitration across the execute-unit streams
// into a one-entry output register. A commit handshake on that register
// performs the architectural register-file write.
module writeback_arbiter_l1 #(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [p_num_pipes-1:0]                        X_val,
  output logic [p_num_pipes-1:0]                        X_rdy,
  input  logic [p_num_pipes-1:0][31:0]                  X_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]    X_seq_num,
  input  logic [p_num_pipes-1:0][4:0]                   X_waddr,
  input  logic [p_num_pipes-1:0][31:0]                  X_wdata,
  input  logic [p_num_pipes-1:0]                        X_wen,
  output logic                                          C_val,
  input  logic                                          C_rdy,
  output logic [31:0]                                   C_pc,
  output logic [p_seq_num_bits-1:0]                     C_seq_num,
  output logic                                          rf_wen,
  output logic [4:0]                                    rf_waddr,
  output logic [31:0]                                   rf_wdata,
  output logic [31:0]                                   num_commits
);

  // A single pipe still gets a 1-bit pointer; it simply never leaves 0.
  localparam int                ptr_w     = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam logic [ptr_w-1:0]  last_pipe = ptr_w'(p_num_pipes - 1);

  // Output register and arbiter state
  logic                       full_q;
  logic [ptr_w-1:0]           ptr_q;
  logic [31:0]                pc_q;
  logic [p_seq_num_bits-1:0]  seq_num_q;
  logic [4:0]                 waddr_q;
  logic [31:0]                wdata_q;
  logic                       wen_q;
  logic [31:0]                num_commits_q;

  // Arbitration results
  logic [p_num_pipes-1:0]     grant;
  logic [ptr_w-1:0]           grant_idx;
  logic                       grant_any;
  logic                       space;
  logic                       accept;
  logic                       fire;

  // Round-robin search: first valid pipe at or after ptr, wrapping around.
  always_comb begin
    int               cand_wide;
    logic [ptr_w-1:0] cand;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; a missing default here would infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_wide = 0;
    cand      = '0;
    for (int k = 0; k < p_num_pipes; k++) begin
      // NOTE: blocking assignments in combinational logic so grant_any
      // updated in one iteration is seen by the next; <= would not be.
      cand_wide = (int'(ptr_q) + k) % p_num_pipes;
      cand      = ptr_w'(cand_wide);
      if (!grant_any && X_val[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Handshake terms: the register can refill in the same cycle it drains.
  assign space  = !full_q || C_rdy;
  assign accept = grant_any && space;
  assign fire   = full_q && C_rdy;
  assign X_rdy  = space ? grant : '0;

  // Commit stream and register-file write port, all from the held entry.
  assign C_val       = full_q;
  assign C_pc        = pc_q;
  assign C_seq_num   = seq_num_q;
  assign rf_wen      = fire && wen_q && (waddr_q != 5'd0);
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign num_commits = num_commits_q;

  // Output register, round-robin pointer and commit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload fields are reset as well, so rf_waddr/rf_wdata and
      // the commit fields are never X after reset even though full_q gates them.
      full_q        <= 1'b0;
      ptr_q         <= '0;
      pc_q          <= '0;
      seq_num_q     <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      num_commits_q <= '0;
    end else begin
      if (accept) begin
        full_q    <= 1'b1;
        pc_q      <= X_pc[grant_idx];
        seq_num_q <= X_seq_num[grant_idx];
        waddr_q   <= X_waddr[grant_idx];
        wdata_q   <= X_wdata[grant_idx];
        wen_q     <= X_wen[grant_idx];
        ptr_q     <= (grant_idx == last_pipe) ? '0 : grant_idx + ptr_w'(1);
      end else if (fire) begin
        full_q <= 1'b0;
      end
      if (fire) begin
        num_commits_q <= num_commits_q + 32'd1;
      end
    end
  end

endmodule

// File: doc/writeback_arbiter_l1.md
# writeback_arbiter_l1

Writeback stage directly downstream of the execute units, including the ALU. It accepts completed-instruction messages from `p_num_pipes` X→W streams, picks one per cycle with a round-robin arbiter, and holds it in a one-entry output register. The held message is presented on a commit stream. When that stream handshakes, the stage performs the architectural register-file write.

## Interface
Parameters:
- `p_num_pipes`, default 2: number of execute units feeding this stage (≥1).
- `p_seq_num_bits`, default 5: width of instruction sequence numbers.

Ports:
- `clk` input, 1: the single clock.
- `rst` input, 1: asynchronous, active-high reset.
- `X_val` input, `p_num_pipes`: per-pipe message valid.
- `X_rdy` output, `p_num_pipes`: per-pipe ready.
- `X_pc` input, `p_num_pipes`×32: per-pipe instruction PC.
- `X_seq_num` input, `p_num_pipes`×`p_seq_num_bits`: per-pipe sequence number.
- `X_waddr` input, `p_num_pipes`×5: per-pipe destination register.
- `X_wdata` input, `p_num_pipes`×32: per-pipe result.
- `X_wen` input, `p_num_pipes`: per-pipe write request.
- `C_val` output, 1: commit message valid.
- `C_rdy` input, 1: commit consumer ready.
- `C_pc` output, 32: committed PC.
- `C_seq_num` output, `p_seq_num_bits`: committed sequence number.
- `rf_wen` output, 1: register-file write enable.
- `rf_waddr` output, 5: register-file write address.
- `rf_wdata` output, 32: register-file write data.
- `num_commits` output, 32: running count of commits.

## Operation
- Output register fields: `full`, `pc`, `seq_num`, `waddr`, `wdata`, `wen`.
- Round-robin state: pointer `ptr`, range 0..`p_num_pipes`-1.
- `C_val` = `full`. `C_pc` and `C_seq_num` are driven from the register.
- Commit handshake: `fire` = `C_val & C_rdy`.
- Register-file outputs:
  - `rf_wen` = `fire & wen & (waddr != 0)`. Writes to x0 are suppressed.
  - `rf_waddr` and `rf_wdata` always reflect the register contents.
- Stage can accept a new message when `space` = `!full | C_rdy`. Draining and refilling in the same cycle is allowed.
- Arbitration:
  - Search starts at `ptr` and wraps modulo `p_num_pipes`.
  - The first `i` with `X_val[i]` is granted.
  - `X_rdy[i]` = `grant[i] & space`. At most one `X_rdy` bit is high per cycle.
  - `X_rdy` is independent of `X_val[i]` only in the sense that a non-valid pipe is never granted.
- On an accepting handshake with pipe `g`:
  - The register loads pipe `g`'s fields and `full` is set to 1.
  - `ptr` becomes (`g`+1) mod `p_num_pipes`.
- On `fire` without an accept: `full` is cleared to 0.
- With no accept, `ptr` is unchanged.
- `num_commits` increments by 1 on each `fire` and wraps from 0xFFFFFFFF to 0.
- No ordering is enforced by `seq_num`. Reordering belongs to the commit consumer.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `full`=0, `ptr`=0, `num_commits`=0.
  - Therefore `C_val`=0, `rf_wen`=0 and `X_rdy`=0 (no grant while no pipe is valid).
  - Data registers reset to 0.
- Reset asserted mid-operation drops any held message. No `rf_wen` occurs in that cycle or afterwards.
- Latency is 1 cycle. A message accepted on edge N appears with `C_val`=1 after edge N.
- Throughput is 1 message per cycle while `C_rdy`=1.
- `C_rdy`=0 with `full`=1: all `X_rdy`=0 and the register holds stable. Upstream must hold its message.
- `rf_wen` is combinational on `C_rdy`. The register file samples on the same edge the commit fires.
- `p_num_pipes`=1: the arbiter degenerates and `ptr` stays 0.

## Test plan
- Single pipe, reset then one message (pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1):
  - `C_val` rises one cycle after accept.
  - `rf_wen`=1 with addr 5 and data 0xDEADBEEF in the fire cycle.
  - `num_commits`=1.
- Write to x0 (waddr=0, wen=1), and wen=0 with waddr=7:
  - Both commit (`num_commits` +2).
  - `rf_wen` stays 0 both times.
- Both pipes valid every cycle, `C_rdy`=1, pipe0 pcs 0x100,0x104,…, pipe1 pcs 0x300,0x304,…:
  - Commit order is 0x100,0x300,0x104,0x304.
  - One commit per cycle and no bubbles.
- `C_rdy` held 0 for 3 cycles with the register full:
  - `X_rdy`=0 throughout and `C_pc` is stable.
  - On release, the drain and the next accept happen in the same cycle.
- Random interval delays on both pipes (0–3 cycles) and on `C_rdy`, 50 messages:
  - All 50 committed exactly once; `num_commits`=50.
  - Per-pipe order is preserved.
  - Register-file writes match the expected list.
- `rst` asserted while `full`=1 and `C_rdy`=0:
  - `C_val` drops immediately and `num_commits`=0.
  - After release, the first grant goes to pipe 0 when both pipes are valid.
